// File: rtl/pdu_debug_ctrl_pkg.sv
// rtl/pdu_debug_ctrl_pkg.sv - shared opcodes, response codes, FSM encodings and helpers
package pdu_debug_ctrl_pkg;

  localparam logic [7:0] OP_BRK   = 8'h42;
  localparam logic [7:0] OP_DEL   = 8'h44;
  localparam logic [7:0] OP_RDCSR = 8'h52;
  localparam logic [7:0] OP_CONT  = 8'h43;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [31:0] BP_DISABLED = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_ARG  = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_CSR_RD   = 3'd3;
  localparam logic [2:0] ST_RUN_REQ  = 3'd4;
  localparam logic [2:0] ST_RUN_WAIT = 3'd5;
  localparam logic [2:0] ST_SEND     = 3'd6;

  function automatic logic [2:0] arg_len(input logic [7:0] op);
    case (op)
      OP_BRK:   return 3'd4;
      OP_RDCSR: return 3'd2;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic no_arg_op(input logic [7:0] op);
    return (op == OP_DEL) || (op == OP_CONT);
  endfunction

endpackage

// File: rtl/pdu_rsp_serializer.sv
// rtl/pdu_rsp_serializer.sv - loads a 32-bit word plus byte count, emits bytes LSB first
module pdu_rsp_serializer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic [7:0]  tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast
);

  logic [31:0] shreg;
  logic [2:0]  count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= 32'h0;
      count <= 3'd0;
    end else if (load) begin
      shreg <= load_data;
      count <= load_count;
    end else if (tvalid && tready) begin
      shreg <= {8'h00, shreg[31:8]};
      count <= count - 3'd1;
    end
  end

  assign tdata  = shreg[7:0];
  assign tvalid = (count != 3'd0);
  assign tlast  = (count == 3'd1);

endmodule

// File: rtl/pdu_debug_ctrl.sv
// rtl/pdu_debug_ctrl.sv - host byte-command debug initiator driving PCU run/breakpoint and CSR reads
module pdu_debug_ctrl
  import pdu_debug_ctrl_pkg::*;
#(
  parameter int ARG_TIMEOUT = 1000,
  parameter int RUN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ready,
  input  logic        cpu_stop,
  output logic        pdu_run,
  output logic [31:0] pdu_breakpoint,
  output logic [31:0] csr_debug_addr,
  input  logic [31:0] csr_debug_dout,
  output logic        busy
);

  localparam int ATW = $clog2(ARG_TIMEOUT + 1);
  localparam int RTW = $clog2(RUN_TIMEOUT + 1);

  logic [2:0]     state, state_nxt;
  logic [7:0]     opcode;
  logic [31:0]    arg;
  logic [1:0]     arg_idx;
  logic [ATW-1:0] arg_tmr;
  logic [RTW-1:0] run_tmr;

  logic        cmd_fire;
  logic        arg_last;
  logic        arg_expired;
  logic        run_expired;
  logic        ser_load;
  logic [31:0] ser_word;
  logic [2:0]  ser_count;
  logic        ser_last;

  assign cmd_ready   = (state == ST_IDLE) || (state == ST_GET_ARG);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign busy        = (state != ST_IDLE);
  assign arg_last    = ({1'b0, arg_idx} == arg_len(opcode) - 3'd1);
  assign arg_expired = (arg_tmr == ATW'(ARG_TIMEOUT));
  assign run_expired = (run_tmr == RTW'(RUN_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    ser_word  = {24'h0, NAK};
    ser_count = 3'd1;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (arg_len(cmd_data) != 3'd0) begin
            state_nxt = ST_GET_ARG;
          end else if (no_arg_op(cmd_data)) begin
            state_nxt = ST_EXEC;
          end else begin
            ser_load  = 1'b1;
            state_nxt = ST_SEND;
          end
        end
      end
      // An arriving byte takes priority over a timeout in the same cycle.
      ST_GET_ARG: begin
        if (cmd_fire) begin
          if (arg_last) state_nxt = ST_EXEC;
        end else if (arg_expired) begin
          ser_load  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_BRK, OP_DEL: begin
            ser_load  = 1'b1;
            ser_word  = {24'h0, ACK};
            state_nxt = ST_SEND;
          end
          OP_RDCSR: state_nxt = ST_CSR_RD;
          OP_CONT: begin
            if (cpu_stop) begin
              state_nxt = ST_RUN_REQ;
            end else begin
              ser_load  = 1'b1;
              state_nxt = ST_SEND;
            end
          end
          default: begin
            ser_load  = 1'b1;
            state_nxt = ST_SEND;
          end
        endcase
      end
      ST_CSR_RD: begin
        ser_load  = 1'b1;
        ser_word  = csr_debug_dout;
        ser_count = 3'd4;
        state_nxt = ST_SEND;
      end
      ST_RUN_REQ: begin
        if (!cpu_stop) begin
          state_nxt = ST_RUN_WAIT;
        end else if (run_expired) begin
          ser_load  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_RUN_WAIT: begin
        if (cpu_stop) begin
          ser_load  = 1'b1;
          ser_word  = {24'h0, ACK};
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (rsp_valid && rsp_ready && ser_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      opcode         <= 8'h00;
      arg            <= 32'h0;
      arg_idx        <= 2'd0;
      arg_tmr        <= '0;
      run_tmr        <= '0;
      pdu_run        <= 1'b0;
      pdu_breakpoint <= BP_DISABLED;
      csr_debug_addr <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            opcode  <= cmd_data;
            arg_idx <= 2'd0;
            arg_tmr <= '0;
          end
        end
        ST_GET_ARG: begin
          if (cmd_fire) begin
            arg[{arg_idx, 3'b000} +: 8] <= cmd_data;
            arg_idx <= arg_idx + 2'd1;
            arg_tmr <= '0;
          end else if (!arg_expired) begin
            arg_tmr <= arg_tmr + 1'b1;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_BRK:   pdu_breakpoint <= arg;
            OP_DEL:   pdu_breakpoint <= BP_DISABLED;
            OP_RDCSR: csr_debug_addr <= {16'h0, arg[15:0]};
            OP_CONT: begin
              if (cpu_stop) begin
                pdu_run <= 1'b1;
                run_tmr <= '0;
              end
            end
            default: ;
          endcase
        end
        ST_RUN_REQ: begin
          if (!cpu_stop || run_expired) pdu_run <= 1'b0;
          else                          run_tmr <= run_tmr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  pdu_rsp_serializer u_ser (
    .clk        (clk),
    .rstn       (rstn),
    .load       (ser_load),
    .load_data  (ser_word),
    .load_count (ser_count),
    .tdata      (rsp_data),
    .tvalid     (rsp_valid),
    .tready     (rsp_ready),
    .tlast      (ser_last)
  );

endmodule
